// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM shift-register sequencer.
// Provides the FSM state encoding, default sizing and the counter-width helper.
package pwm_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } seq_state_t;

   localparam int DEF_NUM_CH = 8;
   localparam int DEF_PERIOD = 100;
   localparam int DEF_DUTY_W = 8;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pwm_shift_sequencer_if.sv
// Duty-write bus and external shift-register control lines of the sequencer.
// The sequencer is the slave (accepts writes, drives the shift register).
interface pwm_shift_sequencer_if
   import pwm_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DUTY_W = DEF_DUTY_W
);
   localparam int ADDR_W = $clog2(NUM_CH);

   logic              duty_wr_en;
   logic [ADDR_W-1:0] duty_wr_addr;
   logic [DUTY_W-1:0] duty_wr_data;
   logic              sr_data;
   logic              sr_shift;
   logic              sr_latch;
   logic              sr_clr;

   modport master (
      output duty_wr_en, duty_wr_addr, duty_wr_data,
      input  sr_data, sr_shift, sr_latch, sr_clr
   );

   modport slave (
      input  duty_wr_en, duty_wr_addr, duty_wr_data,
      output sr_data, sr_shift, sr_latch, sr_clr
   );

endinterface

// File: rtl/pwm_duty_bank.sv
// Per-channel pending/active duty registers and the step compare vector.
// Active duties only change on a period-boundary snapshot so a period never glitches.
module pwm_duty_bank
   import pwm_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DUTY_W = DEF_DUTY_W,
   localparam int ADDR_W = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DUTY_W-1:0] wr_data,
   input  logic              snapshot,
   input  logic [DUTY_W-1:0] step,
   output logic [NUM_CH-1:0] bits
);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DUTY_W-1:0] pending_reg;
         logic [DUTY_W-1:0] active_reg;
         logic [DUTY_W-1:0] duty_eff;

         always_ff @(posedge clk) begin
            if (reset) begin
               pending_reg <= '0;
               active_reg  <= '0;
            end else begin
               if (wr_en && (wr_addr == ADDR_W'(gi)))
                  pending_reg <= wr_data;
               if (snapshot)
                  active_reg <= pending_reg;
            end
         end

         // During the snapshot cycle compare against the value being copied in.
         assign duty_eff = snapshot ? pending_reg : active_reg;
         assign bits[gi] = (step < duty_eff);
      end
   endgenerate

endmodule

// File: rtl/pwm_shift_sequencer.sv
// Multi-channel PWM scheduler: per step, shifts the compare bits out MSB-first
// to an external SIPO register and then pulses its latch, all on one clock.
module pwm_shift_sequencer
   import pwm_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int PERIOD = DEF_PERIOD,
   parameter int DUTY_W = DEF_DUTY_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   pwm_shift_sequencer_if.slave   bus,
   output logic                   busy,
   output logic                   period_tick,
   output logic [DUTY_W-1:0]      step_cnt
);

   localparam int CNT_W = cnt_width(NUM_CH);
   localparam logic [DUTY_W-1:0] LAST_STEP  = DUTY_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(NUM_CH - 1);

   seq_state_t        state_reg, state_next;
   logic [DUTY_W-1:0] step_reg, step_next;
   logic [NUM_CH-1:0] buf_reg, buf_next;
   logic [CNT_W-1:0]  shift_cnt_reg, shift_cnt_next;
   logic              clr_reg;
   logic              snapshot;
   logic [NUM_CH-1:0] bits;

   assign snapshot = (state_reg == LOAD) && (step_reg == '0);

   pwm_duty_bank #(
      .NUM_CH (NUM_CH),
      .DUTY_W (DUTY_W)
   ) u_duty_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (bus.duty_wr_en),
      .wr_addr  (bus.duty_wr_addr),
      .wr_data  (bus.duty_wr_data),
      .snapshot (snapshot),
      .step     (step_reg),
      .bits     (bits)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         step_reg      <= '0;
         buf_reg       <= '0;
         shift_cnt_reg <= '0;
         clr_reg       <= 1'b1;
      end else begin
         state_reg     <= state_next;
         step_reg      <= step_next;
         buf_reg       <= buf_next;
         shift_cnt_reg <= shift_cnt_next;
         clr_reg       <= 1'b0;
      end
   end

   always_comb begin
      state_next     = state_reg;
      step_next      = step_reg;
      buf_next       = buf_reg;
      shift_cnt_next = shift_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (enable)
               state_next = LOAD;
         end
         LOAD: begin
            buf_next       = bits;
            shift_cnt_next = '0;
            state_next     = SHIFT;
         end
         SHIFT: begin
            buf_next       = {buf_reg[NUM_CH-2:0], 1'b0};
            shift_cnt_next = shift_cnt_reg + CNT_W'(1);
            if (shift_cnt_reg == LAST_SHIFT)
               state_next = LATCH;
         end
         LATCH: begin
            step_next  = (step_reg == LAST_STEP) ? '0 : step_reg + DUTY_W'(1);
            state_next = enable ? LOAD : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Strobes decode straight from state, so shift and latch are mutually exclusive.
   assign bus.sr_shift = (state_reg == SHIFT);
   assign bus.sr_latch = (state_reg == LATCH);
   assign bus.sr_data  = (state_reg == SHIFT) && buf_reg[NUM_CH-1];
   assign bus.sr_clr   = clr_reg;
   assign busy         = (state_reg != IDLE);
   assign period_tick  = (state_reg == LATCH) && (step_reg == LAST_STEP);
   assign step_cnt     = step_reg;

endmodule

// File: tb/tb_pwm_shift_sequencer.sv
// Directed bench for pwm_shift_sequencer at default sizing (8 channels, period 100).
// Expected vectors are hand-derived from the duty settings of each period.
module tb_pwm_shift_sequencer;

   localparam int NUM_CH = 8;
   localparam int PERIOD = 100;
   localparam int DUTY_W = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       busy;
   logic       period_tick;
   logic [7:0] step_cnt;

   pwm_shift_sequencer_if #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W)) bus ();

   pwm_shift_sequencer #(
      .NUM_CH (NUM_CH),
      .PERIOD (PERIOD),
      .DUTY_W (DUTY_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .bus         (bus),
      .busy        (busy),
      .period_tick (period_tick),
      .step_cnt    (step_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int latch_cnt = 0;
   int shape_bad = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.sr_latch === 1'b1)
         latch_cnt <= latch_cnt + 1;
   end

   logic [7:0] vec_log [PERIOD];
   logic [7:0] st_log  [PERIOD];
   logic       tick_log[PERIOD];
   int         latch_cyc[PERIOD];

   typedef struct {
      int         step;
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;
   wr_t wq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=event", tag);
   endtask

   task automatic write_duty(input logic [2:0] addr, input logic [7:0] data);
      bus.duty_wr_en   = 1'b1;
      bus.duty_wr_addr = addr;
      bus.duty_wr_data = data;
      @(negedge clk);
      bus.duty_wr_en   = 1'b0;
   endtask

   // Collects one step's serial vector (first bit = channel 7) and the latch-cycle info.
   task automatic capture_step(output logic [7:0] vec, output logic [7:0] st,
                               output logic tick, output int lc);
      int guard;
      guard = 0;
      vec = '0; st = '0; tick = 1'b0; lc = 0;
      while (bus.sr_shift !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         timeout("shift_wait");
         return;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.sr_shift !== 1'b1 || bus.sr_latch !== 1'b0 || busy !== 1'b1) shape_bad++;
         vec[NUM_CH-1-i] = bus.sr_data;
         @(negedge clk);
      end
      if (bus.sr_latch !== 1'b1 || bus.sr_shift !== 1'b0) shape_bad++;
      st   = step_cnt;
      tick = period_tick;
      lc   = cyc;
      @(negedge clk);
      if (bus.sr_latch !== 1'b0) shape_bad++;
   endtask

   task automatic run_period();
      logic [7:0] v, s;
      logic       t;
      int         c;
      wr_t        w;
      for (int k = 0; k < PERIOD; k++) begin
         capture_step(v, s, t, c);
         vec_log[k] = v; st_log[k] = s; tick_log[k] = t; latch_cyc[k] = c;
         if (wq.size() > 0 && wq[0].step == k) begin
            w = wq.pop_front();
            write_duty(w.addr, w.data);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1);
   end

   initial begin
      int n, ticks, p2_tick, l0, guard;
      logic [7:0] v, s;
      logic       t;
      int         c;

      bus.duty_wr_en   = 1'b0;
      bus.duty_wr_addr = '0;
      bus.duty_wr_data = '0;

      // Reset for 3 cycles with enable low
      repeat (3) @(negedge clk);
      check("rst_sr_clr",   bus.sr_clr,   1);
      check("rst_busy",     busy,         0);
      check("rst_sr_shift", bus.sr_shift, 0);
      check("rst_sr_latch", bus.sr_latch, 0);
      check("rst_sr_data",  bus.sr_data,  0);
      check("rst_step",     step_cnt,     0);
      check("rst_tick",     period_tick,  0);
      reset = 1'b0;
      #1;
      check("rel_sr_clr_hold", bus.sr_clr, 1);
      @(negedge clk);
      check("rel_sr_clr_drop", bus.sr_clr, 0);
      check("rel_busy",        busy,       0);

      // Duties 10..80 written while idle
      for (int i = 0; i < NUM_CH; i++) write_duty(3'(i), 8'(10 * (i + 1)));
      repeat (3) @(negedge clk);
      check("idle_busy",    busy,      0);
      check("idle_step",    step_cnt,  0);
      check("idle_latches", latch_cnt, 0);

      // Period 1: duties 10..80, ch0 rewritten to 90 at step 30 (shadowed)
      wq.push_back('{step: 30, addr: 3'd0, data: 8'd90});
      enable = 1'b1;
      run_period();
      check("p1_vec_s0",  vec_log[0],  8'hFF);
      check("p1_vec_s10", vec_log[10], 8'hFE);
      check("p1_vec_s31", vec_log[31], 8'hF8);
      check("p1_vec_s50", vec_log[50], 8'hE0);
      check("p1_st_s50",  st_log[50],  50);
      check("p1_vec_s79", vec_log[79], 8'h80);
      check("p1_vec_s80", vec_log[80], 8'h00);
      check("p1_vec_s99", vec_log[99], 8'h00);
      check("p1_tick_s99", tick_log[99], 1);
      ticks = 0; n = 0;
      for (int k = 0; k < PERIOD; k++) begin
         if (tick_log[k]) ticks++;
         if (st_log[k] == 8'(k)) n++;
      end
      check("p1_tick_count", ticks, 1);
      check("p1_step_seq",   n,     PERIOD);
      check("p1_step_cycles", latch_cyc[51] - latch_cyc[50], 10);
      check("p1_span_cycles", latch_cyc[99] - latch_cyc[0],  990);

      // Period 2: ch0=90 now active; all duties rewritten to 50 (pending only)
      for (int i = 0; i < NUM_CH; i++) wq.push_back('{step: 60 + i, addr: 3'(i), data: 8'd50});
      run_period();
      check("p2_vec_s0",  vec_log[0],  8'hFF);
      check("p2_vec_s50", vec_log[50], 8'hE1);
      check("p2_vec_s85", vec_log[85], 8'h01);
      check("p2_vec_s89", vec_log[89], 8'h01);
      check("p2_vec_s90", vec_log[90], 8'h00);
      check("p2_tick_s99", tick_log[99], 1);
      p2_tick = latch_cyc[99];

      // Period 3: all duties 50; boundary values queued, ch0 written in the step-0 LOAD
      wq.push_back('{step: 60, addr: 3'd1, data: 8'd1});
      wq.push_back('{step: 61, addr: 3'd2, data: 8'd1});
      wq.push_back('{step: 62, addr: 3'd3, data: 8'd0});
      wq.push_back('{step: 63, addr: 3'd4, data: 8'd255});
      wq.push_back('{step: 64, addr: 3'd5, data: 8'd1});
      wq.push_back('{step: 65, addr: 3'd6, data: 8'd1});
      wq.push_back('{step: 66, addr: 3'd7, data: 8'd1});
      wq.push_back('{step: 99, addr: 3'd0, data: 8'd1});
      run_period();
      n = 0;
      for (int k = 0; k < PERIOD; k++)
         if (vec_log[k] == ((k < 50) ? 8'hFF : 8'h00)) n++;
      check("p3_half_duty", n, PERIOD);
      check("p3_vec_s49", vec_log[49], 8'hFF);
      check("p3_vec_s50", vec_log[50], 8'h00);
      check("p3_tick_s99", tick_log[99], 1);
      check("p3_tick_interval", latch_cyc[99] - p2_tick, 1000);

      // Period 4: ch0 still 50 (write coincided with the snapshot), ch3=0, ch4=255, rest 1
      run_period();
      n = 0;
      for (int k = 0; k < PERIOD; k++)
         if (vec_log[k] == ((k == 0) ? 8'hF7 : (k < 50) ? 8'h11 : 8'h10)) n++;
      check("p4_boundaries", n, PERIOD);
      check("p4_vec_s0",  vec_log[0],  8'hF7);
      check("p4_vec_s49", vec_log[49], 8'h11);
      check("p4_vec_s99", vec_log[99], 8'h10);

      // Period 5: ch0=1 now active
      run_period();
      n = 0;
      for (int k = 0; k < PERIOD; k++)
         if (vec_log[k] == ((k == 0) ? 8'hF7 : 8'h10)) n++;
      check("p5_boundaries", n, PERIOD);
      check("p5_vec_s1", vec_log[1], 8'h10);
      check("shape_errors", shape_bad, 0);

      // Drop enable mid-SHIFT of step 0: step completes, one latch, then idle
      guard = 0;
      while (bus.sr_shift !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      if (guard >= 20) timeout("dis_shift_wait");
      repeat (3) @(negedge clk);
      l0 = latch_cnt;
      enable = 1'b0;
      guard = 0;
      while (busy !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
      if (guard >= 20) timeout("dis_idle_wait");
      check("dis_latches", latch_cnt - l0, 1);
      check("dis_step",    step_cnt,       1);
      repeat (20) @(negedge clk);
      check("dis_hold_step",    step_cnt,       1);
      check("dis_hold_latches", latch_cnt - l0, 1);
      check("dis_hold_shift",   bus.sr_shift,   0);

      enable = 1'b1;
      capture_step(v, s, t, c);
      check("resume_step", s, 1);
      check("resume_vec",  v, 8'h10);

      // Reset mid-SHIFT: abort without latch, everything cleared
      guard = 0;
      while (bus.sr_shift !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      if (guard >= 20) timeout("rst_shift_wait");
      repeat (2) @(negedge clk);
      l0 = latch_cnt;
      reset  = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("mrst_sr_clr", bus.sr_clr,   1);
      check("mrst_busy",   busy,         0);
      check("mrst_step",   step_cnt,     0);
      check("mrst_shift",  bus.sr_shift, 0);
      repeat (8) @(negedge clk);
      check("mrst_no_latch", latch_cnt - l0, 0);
      reset = 1'b0;
      @(negedge clk);
      check("mrst_clr_drop", bus.sr_clr, 0);
      enable = 1'b1;
      capture_step(v, s, t, c);
      check("mrst_duties_zero", v, 8'h00);
      check("mrst_step0",       s, 0);
      enable = 1'b0;
      repeat (12) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
